// File: rtl/sfifo_pkg.sv
// Shared constants and helpers for the sfifo write-side arbiter.
// The level/credit counter must hold 0..DEPTH inclusive, hence clog2_p1.
package sfifo_pkg;

  localparam int DEF_DW    = 8;
  localparam int DEF_DEPTH = 8;

  function automatic int clog2_p1(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sfifo_rr_pick.sv
// Combinational round-robin picker: rotate eligible by ptr, take the lowest
// set bit, then map that position back to an absolute producer index.
module sfifo_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   win
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic              found;
  int                pos;
  int                idx;

  always_comb begin
    dbl   = {eligible, eligible} >> ptr;
    rot   = dbl[NREQ-1:0];
    found = 1'b0;
    pos   = 0;
    // Descending scan so the lowest rotated position wins.
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        found = 1'b1;
        pos   = j;
      end
    end
    idx = int'(ptr) + pos;
    if (idx >= NREQ) idx = idx - NREQ;
    gnt = '0;
    win = '0;
    if (found) begin
      gnt[idx] = 1'b1;
      win      = PW'(idx);
    end
  end

endmodule

// File: rtl/sfifo_wr_arb.sv
// Round-robin arbiter sharing one sfifo write port among NREQ producers.
// A registered credit counter gates grants, so FIFO status never reaches gnt.
module sfifo_wr_arb
  import sfifo_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH,
  localparam int CW   = clog2_p1(DEPTH),
  localparam int PW   = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] din_bus,
  output logic [NREQ-1:0]    gnt,
  output logic               fifo_w_en,
  output logic [DW-1:0]      fifo_din,
  input  logic               fifo_r_en,
  input  logic               fifo_empty,
  input  logic               fifo_overflow,
  output logic [CW-1:0]      level,
  output logic               err
);

  logic [CW-1:0]   credits_q, credits_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            fifo_w_en_q, fifo_w_en_d;
  logic [DW-1:0]   fifo_din_q, fifo_din_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] pick_gnt;
  logic [PW-1:0]   win;
  logic [DW-1:0]   sel_din;
  logic            push;
  logic            pop;
  logic            sat_pop;

  assign eligible = (credits_q != '0) ? req : '0;

  sfifo_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .gnt      (pick_gnt),
    .win      (win)
  );

  // Grants are suppressed while rst is held, even though credits read full.
  assign gnt     = rst ? '0 : pick_gnt;
  assign push    = |gnt;
  assign pop     = fifo_r_en & ~fifo_empty;
  assign sat_pop = pop && (credits_q == CW'(DEPTH));

  always_comb begin
    sel_din = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) sel_din = din_bus[i*DW +: DW];
    end
  end

  always_comb begin
    credits_d = credits_q;
    if (push && !pop) begin
      credits_d = credits_q - CW'(1);
    end else if (pop && !push && !sat_pop) begin
      credits_d = credits_q + CW'(1);
    end

    ptr_d = ptr_q;
    if (push) ptr_d = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);

    fifo_w_en_d = push;
    fifo_din_d  = push ? sel_din : fifo_din_q;
    err_d       = err_q | fifo_overflow | sat_pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q   <= CW'(DEPTH);
      ptr_q       <= '0;
      fifo_w_en_q <= 1'b0;
      fifo_din_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      credits_q   <= credits_d;
      ptr_q       <= ptr_d;
      fifo_w_en_q <= fifo_w_en_d;
      fifo_din_q  <= fifo_din_d;
      err_q       <= err_d;
    end
  end

  assign fifo_w_en = fifo_w_en_q;
  assign fifo_din  = fifo_din_q;
  assign level     = CW'(DEPTH) - credits_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sfifo_wr_arb.sv
// Directed bench for sfifo_wr_arb (NREQ=4, DW=8, DEPTH=8).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_sfifo_wr_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] din_bus;
  logic [3:0]  gnt;
  logic        fifo_w_en;
  logic [7:0]  fifo_din;
  logic        fifo_r_en;
  logic        fifo_empty;
  logic        fifo_overflow;
  logic [3:0]  level;
  logic        err;

  int n_cmp = 0;
  int n_mis = 0;
  int cnt [4];

  sfifo_wr_arb #(.NREQ(4), .DW(8), .DEPTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .din_bus       (din_bus),
    .gnt           (gnt),
    .fifo_w_en     (fifo_w_en),
    .fifo_din      (fifo_din),
    .fifo_r_en     (fifo_r_en),
    .fifo_empty    (fifo_empty),
    .fifo_overflow (fifo_overflow),
    .level         (level),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    req           = '0;
    din_bus       = '0;
    fifo_r_en     = 1'b0;
    fifo_empty    = 1'b1;
    fifo_overflow = 1'b0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset and idle, with requests asserted during reset to prove gnt is held off
    rst = 1'b1; req = 4'hF; din_bus = '0;
    fifo_r_en = 1'b0; fifo_empty = 1'b1; fifo_overflow = 1'b0;
    #1;
    check_eq("rst_gnt", gnt, 4'h0);
    repeat (4) step();
    check_eq("rst_wen", fifo_w_en, 1'b0);
    check_eq("rst_din", fifo_din, 8'h00);
    check_eq("rst_level", level, 4'd0);
    check_eq("rst_err", err, 1'b0);
    req = '0;
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check_eq("idle_wen", fifo_w_en, 1'b0);
      check_eq("idle_gnt", gnt, 4'h0);
      check_eq("idle_level", level, 4'd0);
      check_eq("idle_err", err, 1'b0);
    end

    // Single producer streaming three words back to back
    for (int n = 0; n < 3; n++) begin
      req = 4'b0010;
      din_bus[15:8] = 8'h75 + 8'(n);
      #1;
      check_eq("single_gnt", gnt, 4'b0010);
      step();
      check_eq("single_wen", fifo_w_en, 1'b1);
      check_eq("single_din", fifo_din, 8'h75 + 8'(n));
      check_eq("single_level", level, 4'(n + 1));
    end
    req = '0;
    #1;
    check_eq("single_gnt_off", gnt, 4'h0);
    step();
    check_eq("single_wen_off", fifo_w_en, 1'b0);
    check_eq("single_din_hold", fifo_din, 8'h77);
    check_eq("single_level3", level, 4'd3);

    // Round robin from ptr=0 until credits run out
    do_reset();
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    req = 4'hF;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++) din_bus[i*8 +: 8] = 8'(8'h10 * i + cnt[i]);
      #1;
      check_eq("rr_gnt", gnt, 4'b0001 << (k % 4));
      step();
      cnt[k % 4]++;
      check_eq("rr_wen", fifo_w_en, 1'b1);
      check_eq("rr_din", fifo_din, 8'(8'h10 * (k % 4) + k / 4));
    end
    for (int i = 0; i < 4; i++) din_bus[i*8 +: 8] = 8'(8'h10 * i + cnt[i]);
    #1;
    check_eq("rr_full_gnt", gnt, 4'h0);
    check_eq("rr_full_level", level, 4'd8);

    // Credit return while full: the freed slot is usable only next cycle
    fifo_r_en = 1'b1; fifo_empty = 1'b0;
    #1;
    check_eq("cr_pop_gnt", gnt, 4'h0);
    step();
    check_eq("cr_pop_wen", fifo_w_en, 1'b0);
    check_eq("cr_level7", level, 4'd7);
    fifo_r_en = 1'b0;
    #1;
    check_eq("cr_gnt", gnt, 4'b0001);
    step();
    check_eq("cr_wen", fifo_w_en, 1'b1);
    check_eq("cr_din", fifo_din, 8'h02);
    check_eq("cr_level8", level, 4'd8);
    check_eq("cr_gnt_off", gnt, 4'h0);
    check_eq("cr_err", err, 1'b0);

    // Simultaneous push and pop at level 4
    do_reset();
    req = 4'b0100;
    for (int n = 0; n < 4; n++) begin
      din_bus[23:16] = 8'hA0 + 8'(n);
      step();
    end
    check_eq("pp_level_start", level, 4'd4);
    fifo_r_en = 1'b1; fifo_empty = 1'b0;
    for (int n = 0; n < 5; n++) begin
      din_bus[23:16] = 8'hB0 + 8'(n);
      #1;
      check_eq("pp_gnt", gnt, 4'b0100);
      step();
      check_eq("pp_din", fifo_din, 8'hB0 + 8'(n));
      check_eq("pp_level", level, 4'd4);
    end
    req = '0; fifo_r_en = 1'b0;
    check_eq("pp_err", err, 1'b0);

    // Pop with FIFO believed empty saturates credits and sets err
    do_reset();
    fifo_r_en = 1'b1; fifo_empty = 1'b0;
    step();
    fifo_r_en = 1'b0;
    check_eq("sat_err", err, 1'b1);
    check_eq("sat_level", level, 4'd0);
    step();
    check_eq("sat_err_sticky", err, 1'b1);

    // Overflow flag sets sticky err; mid-flight reset discards the write
    do_reset();
    check_eq("ovf_err_clear", err, 1'b0);
    fifo_overflow = 1'b1;
    step();
    fifo_overflow = 1'b0;
    check_eq("ovf_err", err, 1'b1);
    repeat (3) step();
    check_eq("ovf_err_sticky", err, 1'b1);
    req = 4'b1000; din_bus[31:24] = 8'h5A;
    step();
    check_eq("mid_wen", fifo_w_en, 1'b1);
    check_eq("mid_din", fifo_din, 8'h5A);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_wen", fifo_w_en, 1'b0);
    check_eq("mid_rst_gnt", gnt, 4'h0);
    check_eq("mid_rst_level", level, 4'd0);
    check_eq("mid_rst_err", err, 1'b0);
    step();
    rst = 1'b0; req = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/sfifo_wr_arb.md
Name: sfifo_wr_arb

Overview:
Round-robin write arbiter that shares the single write port of one sfifo instance among NREQ producers. Sits directly in front of sfifo (fifo_w_en/fifo_din drive sfifo w_en/din). Tracks free FIFO slots with a registered credit counter, so it never writes into a full FIFO and has no combinational path from sfifo status to its grants. Also flags credit/FIFO inconsistencies.

Parameters:
NREQ, 4, number of producers (2..8)
DW, 8, data width; matches sfifo din/dout
DEPTH, 8, sfifo depth in words; initial credit count

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
req  in  NREQ  per-producer request; data valid on din_bus slice
din_bus  in  NREQ*DW  producer data, slice i = bits [i*DW +: DW]
gnt  out  NREQ  one-hot combinational grant; word i accepted at this clock edge
fifo_w_en  out  1  registered write enable to sfifo w_en
fifo_din  out  DW  registered write data to sfifo din
fifo_r_en  in  1  sfifo read enable (credit return)
fifo_empty  in  1  sfifo empty
fifo_overflow  in  1  sfifo overflow flag
level  out  $clog2(DEPTH+1)  words committed to FIFO = DEPTH - credits
err  out  1  sticky error

Behaviour:
- Reset (async assert, sync-released by the system): fifo_w_en=0, fifo_din=0, credits=DEPTH (level=0), ptr=0, err=0. gnt=0 while rst=1.
- Handshake: valid/ready per producer. Word i transfers at the edge where req[i]&gnt[i]=1; producer holds req and data stable until then; after the transfer it may present the next word immediately.
- Arbitration (combinational, each cycle): eligible = req when credits>0, else 0. Winner = first eligible index scanning ptr, ptr+1, ... modulo NREQ. gnt = one-hot winner, or 0 if none eligible.
- gnt depends only on req, ptr and credits; no input-to-gnt path other than req.
- Pointer: on a grant to i, ptr <= (i+1) mod NREQ; with no grant, ptr holds.
- Output stage, 1-cycle latency: on a grant to i, fifo_w_en <= 1 and fifo_din <= slice i. Otherwise fifo_w_en <= 0 and fifo_din holds its last value.
- Throughput: one word per clock aggregate. A single continuously requesting producer is granted every cycle.
- Credits: push = |gnt; pop = fifo_r_en & ~fifo_empty.
  - credits_next = credits - push + pop. Simultaneous push and pop leaves credits unchanged.
  - credits==0: no grant, even if pop occurs in the same cycle. The returned credit becomes usable the next cycle.
  - pop with credits==DEPTH: credits saturate at DEPTH and err is set.
- err: set by the saturating pop above or by fifo_overflow=1 on any edge. Cleared only by rst.
- Fairness: with all NREQ requesting continuously, grants rotate 0,1,...,NREQ-1,0,... Worst-case wait is NREQ-1 cycles while credits are available.
- Reset mid-operation: an in-flight registered write is discarded (fifo_w_en forced 0). sfifo must be reset on the same rst so that level=0 stays consistent.

Decomposition:
- Package sfifo_pkg: default DW and DEPTH constants, function clog2_p1(n)=$clog2(n+1) for the level/credit width.
- One sub-module, sfifo_rr_pick: combinational rotate–priority-encode–unrotate picker.
  - Inputs: eligible[NREQ], ptr.
  - Outputs: one-hot gnt, winner index.
  - All registers (ptr, credits, output stage, err) stay in sfifo_wr_arb.

Test Plan:
- Reset then idle: rst high 4 cycles, then low, req=0 -> fifo_w_en=0, gnt=0, level=0, err=0 for 10 cycles.
- Single producer: DEPTH=8, req[1]=1 with data 8'h75,8'h76,8'h77 on successive grants -> gnt=4'b0010 three cycles; fifo_w_en=1 one cycle later each; fifo_din=75,76,77; level=3.
- Round-robin: all four request continuously, producer i sends 8'h10*i+n, no reads -> grant order 0,1,2,3,0,1,2,3; fifo_din 00,10,20,30,01,11,21,31; gnt=0 after 8 grants; level=8.
- Full/credit return: after the previous test, pulse fifo_r_en with fifo_empty=0 for 1 cycle -> no grant that cycle, exactly one grant (producer 0, data 8'h02) the next cycle; level back to 8.
- Simultaneous push/pop: level=4, req[2]=1 and fifo_r_en=1 for 5 cycles -> 5 grants, level stays 4, err=0.
- Errors: fifo_r_en=1 with fifo_empty=0 at level=0 -> err=1, level=0. Separately, fifo_overflow=1 for one cycle -> err=1 until rst, and fifo_w_en=0 during rst.
